// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one ALU between two requesters.
// A round-robin arbiter issues at most one operation per cycle. The ALU inputs are
// driven from the granted requester's payload. The ALU result and flags are captured,
// together with the issuing requester's id, in a one-entry valid/ready response register.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   reqN_vld_i / reqN_*_i   requester N operation (opcode, src1, src0, shamt), N = 0, 1
//   reqN_rdy_o              requester N operation accepted this cycle
//   alu_*_o                 operands to the shared ALU
//   alu_*_i                 ALU result and flags (dst, ov, zr, n)
//   rsp_*_o                 held response (vld, id, dst, ov, zr, n)
//   rsp_rdy_i               consumer takes the response this cycle
module alu_share_arb #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned OPS_W   = 3,
  parameter int unsigned SHAMT_W = 4,
  parameter bit          RR_INIT = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req0_vld_i,
  input  logic [OPS_W-1:0]   req0_ops_i,
  input  logic [DATA_W-1:0]  req0_src1_i,
  input  logic [DATA_W-1:0]  req0_src0_i,
  input  logic [SHAMT_W-1:0] req0_shamt_i,
  output logic               req0_rdy_o,
  input  logic               req1_vld_i,
  input  logic [OPS_W-1:0]   req1_ops_i,
  input  logic [DATA_W-1:0]  req1_src1_i,
  input  logic [DATA_W-1:0]  req1_src0_i,
  input  logic [SHAMT_W-1:0] req1_shamt_i,
  output logic               req1_rdy_o,
  output logic [OPS_W-1:0]   alu_ops_o,
  output logic [DATA_W-1:0]  alu_src1_o,
  output logic [DATA_W-1:0]  alu_src0_o,
  output logic [SHAMT_W-1:0] alu_shamt_o,
  input  logic [DATA_W-1:0]  alu_dst_i,
  input  logic               alu_ov_i,
  input  logic               alu_zr_i,
  input  logic               alu_n_i,
  output logic               rsp_vld_o,
  output logic               rsp_id_o,
  output logic [DATA_W-1:0]  rsp_dst_o,
  output logic               rsp_ov_o,
  output logic               rsp_zr_o,
  output logic               rsp_n_o,
  input  logic               rsp_rdy_i
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic        slot_free;
  logic        gnt0, gnt1;
  logic        xfer;

  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_dst_q, rsp_dst_d;
  logic              rsp_ov_q, rsp_ov_d;
  logic              rsp_zr_q, rsp_zr_d;
  logic              rsp_n_q, rsp_n_d;

  // State register; last_gnt starts at ~RR_INIT so the first tie goes to RR_INIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StEmpty;
      last_gnt_q <= ~RR_INIT;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Arbitration: the slot is free when empty, or when the held response leaves this cycle.
  always_comb begin
    slot_free = (state_q == StEmpty) || rsp_rdy_i;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (slot_free) begin
      if (req0_vld_i && req1_vld_i) begin
        gnt0 = last_gnt_q;
        gnt1 = ~last_gnt_q;
      end else begin
        gnt0 = req0_vld_i;
        gnt1 = req1_vld_i;
      end
    end
    // A grant is only given to a valid requester, so a grant is a transfer.
    xfer = gnt0 || gnt1;
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = xfer ? gnt1 : last_gnt_q;
    unique case (state_q)
      StEmpty: if (xfer) state_d = StFull;
      StFull:  if (rsp_rdy_i && !xfer) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // Outputs: grants and the ALU operand mux.
  always_comb begin
    req0_rdy_o  = gnt0;
    req1_rdy_o  = gnt1;
    rsp_vld_o   = (state_q == StFull);
    alu_ops_o   = '0;
    alu_src1_o  = '0;
    alu_src0_o  = '0;
    alu_shamt_o = '0;
    if (gnt0) begin
      alu_ops_o   = req0_ops_i;
      alu_src1_o  = req0_src1_i;
      alu_src0_o  = req0_src0_i;
      alu_shamt_o = req0_shamt_i;
    end else if (gnt1) begin
      alu_ops_o   = req1_ops_i;
      alu_src1_o  = req1_src1_i;
      alu_src0_o  = req1_src0_i;
      alu_shamt_o = req1_shamt_i;
    end
  end

  // Response payload: loaded only on a transfer, otherwise held bit-stable.
  always_comb begin
    rsp_id_d  = rsp_id_q;
    rsp_dst_d = rsp_dst_q;
    rsp_ov_d  = rsp_ov_q;
    rsp_zr_d  = rsp_zr_q;
    rsp_n_d   = rsp_n_q;
    if (xfer) begin
      rsp_id_d  = gnt1;
      rsp_dst_d = alu_dst_i;
      rsp_ov_d  = alu_ov_i;
      rsp_zr_d  = alu_zr_i;
      rsp_n_d   = alu_n_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_id_q  <= 1'b0;
      rsp_dst_q <= '0;
      rsp_ov_q  <= 1'b0;
      rsp_zr_q  <= 1'b0;
      rsp_n_q   <= 1'b0;
    end else begin
      rsp_id_q  <= rsp_id_d;
      rsp_dst_q <= rsp_dst_d;
      rsp_ov_q  <= rsp_ov_d;
      rsp_zr_q  <= rsp_zr_d;
      rsp_n_q   <= rsp_n_d;
    end
  end

  assign rsp_id_o  = rsp_id_q;
  assign rsp_dst_o = rsp_dst_q;
  assign rsp_ov_o  = rsp_ov_q;
  assign rsp_zr_o  = rsp_zr_q;
  assign rsp_n_o   = rsp_n_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a behavioural 16-bit ALU, a cycle-level reference model of the
// arbiter/response slot, directed scenarios with literal expectations, then random traffic.
module tb_alu_share_arb;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpOr  = 3'd3;

  logic        clk;
  logic        rst_n;
  logic        req0_vld, req1_vld, req0_rdy, req1_rdy;
  logic [2:0]  req0_ops, req1_ops, alu_ops;
  logic [15:0] req0_src1, req0_src0, req1_src1, req1_src0, alu_src1, alu_src0, alu_dst;
  logic [3:0]  req0_shamt, req1_shamt, alu_shamt;
  logic        alu_ov, alu_zr, alu_n;
  logic        rsp_vld, rsp_id, rsp_ov, rsp_zr, rsp_n, rsp_rdy;
  logic [15:0] rsp_dst;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_full, m_last, m_g0, m_g1;
  logic        m_id, m_ov, m_zr, m_n;
  logic [15:0] m_dst;

  alu_share_arb #(
    .DATA_W (16),
    .OPS_W  (3),
    .SHAMT_W(4),
    .RR_INIT(1'b0)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req0_vld_i  (req0_vld),
    .req0_ops_i  (req0_ops),
    .req0_src1_i (req0_src1),
    .req0_src0_i (req0_src0),
    .req0_shamt_i(req0_shamt),
    .req0_rdy_o  (req0_rdy),
    .req1_vld_i  (req1_vld),
    .req1_ops_i  (req1_ops),
    .req1_src1_i (req1_src1),
    .req1_src0_i (req1_src0),
    .req1_shamt_i(req1_shamt),
    .req1_rdy_o  (req1_rdy),
    .alu_ops_o   (alu_ops),
    .alu_src1_o  (alu_src1),
    .alu_src0_o  (alu_src0),
    .alu_shamt_o (alu_shamt),
    .alu_dst_i   (alu_dst),
    .alu_ov_i    (alu_ov),
    .alu_zr_i    (alu_zr),
    .alu_n_i     (alu_n),
    .rsp_vld_o   (rsp_vld),
    .rsp_id_o    (rsp_id),
    .rsp_dst_o   (rsp_dst),
    .rsp_ov_o    (rsp_ov),
    .rsp_zr_o    (rsp_zr),
    .rsp_n_o     (rsp_n),
    .rsp_rdy_i   (rsp_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Saturating 16-bit ALU; returns {ov, zr, n, dst}.
  function automatic logic [18:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] sh);
    logic [15:0] r;
    logic [16:0] s;
    logic        ov;
    ov = 1'b0;
    s  = '0;
    case (op)
      3'd0, 3'd1: begin
        s = (op == 3'd0) ? ({a[15], a} + {b[15], b}) : ({a[15], a} - {b[15], b});
        if (s[16] != s[15]) begin
          ov = 1'b1;
          r  = s[16] ? 16'h8000 : 16'h7FFF;
        end else begin
          r = s[15:0];
        end
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = a << sh;
      3'd6:    r = a >> sh;
      default: r = $signed(a) >>> sh;
    endcase
    return {ov, (r == 16'h0000), r[15], r};
  endfunction

  assign {alu_ov, alu_zr, alu_n, alu_dst} = alu_fn(alu_ops, alu_src1, alu_src0, alu_shamt);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks the DUT against the model, then advances the model across
  // the coming rising edge.
  always @(negedge clk) begin
    logic        slot;
    logic [18:0] r;
    logic [2:0]  e_ops;
    logic [15:0] e_s1, e_s0;
    logic [3:0]  e_sh;
    if (!rst_n) begin
      check("rst_vld", rsp_vld, 0);
      check("rst_id", rsp_id, 0);
      check("rst_dst", rsp_dst, 0);
      check("rst_flags", {rsp_ov, rsp_zr, rsp_n}, 0);
      m_full = 1'b0;
      m_last = 1'b1;  // ~RR_INIT
      m_g0   = 1'b0;
      m_g1   = 1'b0;
    end else begin
      check("rsp_vld", rsp_vld, m_full);
      if (m_full) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_dst", rsp_dst, m_dst);
        check("rsp_flags", {rsp_ov, rsp_zr, rsp_n}, {m_ov, m_zr, m_n});
      end
      slot = !m_full || rsp_rdy;
      m_g0 = slot && req0_vld && (!req1_vld || m_last);
      m_g1 = slot && req1_vld && (!req0_vld || !m_last);
      check("req0_rdy", req0_rdy, m_g0);
      check("req1_rdy", req1_rdy, m_g1);
      e_ops = '0; e_s1 = '0; e_s0 = '0; e_sh = '0;
      if (m_g0) begin
        e_ops = req0_ops; e_s1 = req0_src1; e_s0 = req0_src0; e_sh = req0_shamt;
      end else if (m_g1) begin
        e_ops = req1_ops; e_s1 = req1_src1; e_s0 = req1_src0; e_sh = req1_shamt;
      end
      check("alu_operands", {alu_ops, alu_shamt, alu_src1, alu_src0}, {e_ops, e_sh, e_s1, e_s0});
      if (m_g0 || m_g1) begin
        r = alu_fn(e_ops, e_s1, e_s0, e_sh);
        {m_ov, m_zr, m_n, m_dst} = r;
        m_id   = m_g1;
        m_last = m_g1;
        m_full = 1'b1;
      end else if (rsp_rdy) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] sh);
    req0_vld = v; req0_ops = op; req0_src1 = a; req0_src0 = b; req0_shamt = sh;
  endtask

  task automatic drive1(input logic v, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] sh);
    req1_vld = v; req1_ops = op; req1_src1 = a; req1_src0 = b; req1_shamt = sh;
  endtask

  initial begin
    rst_n   = 1'b0;
    rsp_rdy = 1'b0;
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    repeat (3) step();
    rst_n = 1'b1;

    // 1: saturating add from requester 0
    step();
    drive0(1, OpAdd, 16'h7000, 16'h1000, 0);
    rsp_rdy = 1'b1;
    mid();
    check("t1_rdy0", req0_rdy, 1);
    // 2: requester 1 alone, granted in the same cycle
    step();
    req0_vld = 1'b0;
    drive1(1, OpSub, 16'h0005, 16'h0005, 0);
    mid();
    check("t1_vld", rsp_vld, 1);
    check("t1_id", rsp_id, 0);
    check("t1_dst", rsp_dst, 16'h7FFF);
    check("t1_ov_zr", {rsp_ov, rsp_zr}, 2'b10);
    check("t2_rdy1", req1_rdy, 1);
    step();
    req1_vld = 1'b0;
    mid();
    check("t2_id", rsp_id, 1);
    check("t2_dst", rsp_dst, 16'h0000);
    check("t2_ov_zr", {rsp_ov, rsp_zr}, 2'b01);

    // 3: both valid for 6 cycles, alternating grants
    step();
    drive0(1, OpAdd, 16'h0001, 16'h0002, 0);
    drive1(1, OpOr, 16'h0003, 16'h0004, 0);
    for (int i = 0; i < 6; i++) begin
      mid();
      check("t3_gnt", {req0_rdy, req1_rdy}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0) check("t3_vld", rsp_vld, 1);
      step();
    end

    // 4: stall with both valid, then resume with the other requester
    mid();
    check("t4_gnt0", req0_rdy, 1);
    step();
    rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("t4_stall_rdy", {req0_rdy, req1_rdy}, 2'b00);
      check("t4_hold", {rsp_vld, rsp_id, rsp_dst}, {1'b1, 1'b0, 16'h0003});
      step();
    end
    rsp_rdy = 1'b1;
    mid();
    check("t4_resume", {req0_rdy, req1_rdy}, 2'b01);
    step();
    req1_vld = 1'b0;
    mid();
    check("t4_next0", req0_rdy, 1);
    step();
    req0_vld = 1'b0;

    // 5: reset while full; first tie afterwards goes to requester 0
    rsp_rdy = 1'b0;
    #1;
    check("t5_full", rsp_vld, 1);
    rst_n = 1'b0;
    #1;
    check("t5_async", rsp_vld, 0);
    step();
    step();
    rst_n = 1'b1;
    rsp_rdy = 1'b1;
    req0_vld = 1'b1;
    req1_vld = 1'b1;
    mid();
    check("t5_tie", {req0_rdy, req1_rdy}, 2'b10);

    // Random traffic; requesters hold an op until it is accepted.
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i == 1500) begin
        rst_n    = 1'b0;
        req0_vld = 1'b0;
        req1_vld = 1'b0;
      end else if (i > 1500 && i < 1503) begin
        if (i == 1502) rst_n = 1'b1;
      end else begin
        if (!(req0_vld && !m_g0))
          drive0($urandom_range(0, 99) < 60, 3'($urandom), 16'($urandom), 16'($urandom),
                 4'($urandom));
        if (!(req1_vld && !m_g1))
          drive1($urandom_range(0, 99) < 60, 3'($urandom), 16'($urandom), 16'($urandom),
                 4'($urandom));
        rsp_rdy = $urandom_range(0, 99) < 70;
      end
    end
    step();
    mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
